emul_demux_sm_axil: RTL and testbench

- Parametrised successor to the 4-register AXI4-Lite emulation slave.
- Keeps a configurable AXI4-Lite register bank (control, status, scratch, per-channel beat counters).
- Adds a buffered valid/ready stream demultiplexer. It routes one input stream to one of NUM_CH outputs, chosen by software or by round-robin.
- Sits behind the PS AXI interconnect; the stream ports connect to emulation datapath IP.

---
 rtl/emul_demux_sm_axil.sv | 275 +++++++++++++++++++++++++++
 tb/tb_emul_demux_sm_axil.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emul_demux_sm_axil.sv
// AXI4-Lite register bank plus a one-entry buffered valid/ready stream demultiplexer.
// Optional EMUL_DEMUX_SEL_CHECK_EN: drop beats for out-of-range SEL, count drops, SLVERR on bad SEL writes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | stream input closed, buffer empty
// RUN     | beats accepted and routed to the latched channel
// DRAIN   | input closed, waiting for the buffered beat to be consumed
module emul_demux_sm_axil #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 4,
  parameter int DATA_W             = 16,
  parameter int CNT_W              = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [DATA_W-1:0]               s_tdata,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  output logic [DATA_W-1:0]               m_tdata,
  output logic [NUM_CH-1:0]               m_tvalid,
  input  logic [NUM_CH-1:0]               m_tready
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] LAST_CH     = 4'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              en_q, en_d;
  logic              auto_q, auto_d;
  logic [3:0]        sel_q, sel_d;
  logic [DW-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic              full_q, full_d;
  logic [3:0]        buf_ch_q, buf_ch_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [3:0]        rr_ptr_q, rr_ptr_d;
  logic [15:0]       drop_q, drop_d;

  logic              wr_en, rd_en, wr_ctrl, wr_scratch;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [NUM_CH-1:0] cnt_clr;
  logic [DW-1:0]     ctrl_rd, status_rd, rd_mux;
  logic [NUM_CH-1:0] mvalid, hs;
  logic              drain, s_ready, accept, drop, load;
  logic [3:0]        tgt_ch;
  logic              unused_sigs;

  function automatic logic [3:0] clamp_ch(input logic [3:0] ch);
    return (ch > LAST_CH) ? LAST_CH : ch;
  endfunction

  function automatic logic [3:0] next_ch(input logic [3:0] ch);
    return (ch >= LAST_CH) ? 4'd0 : ch + 4'd1;
  endfunction

  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_en      = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en      = arready_q & S_AXI_ARVALID;
  assign wr_idx     = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_ctrl    = wr_en & (wr_idx == IDX_W'(0));
  assign wr_scratch = wr_en & (wr_idx == IDX_W'(2));

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_clr[k] = wr_en & (wr_idx == IDX_W'(3 + k));
    end
  end

  assign ctrl_rd   = DW'({auto_q, sel_q, 3'b000, en_q});
  assign status_rd = {drop_q, 8'h00, (full_q ? buf_ch_q : 4'h0), 1'b0, state_q, full_q};

  always_comb begin
    rd_mux = '0;
    if (rd_idx == IDX_W'(0))      rd_mux = ctrl_rd;
    else if (rd_idx == IDX_W'(1)) rd_mux = status_rd;
    else if (rd_idx == IDX_W'(2)) rd_mux = scratch_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_idx == IDX_W'(3 + k)) rd_mux = DW'(cnt_q[k]);
    end
  end

  // AXI handshakes: ready pulses one cycle, response held until accepted
  always_comb begin
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
`ifdef EMUL_DEMUX_SEL_CHECK_EN
      if (wr_ctrl && S_AXI_WSTRB[0] && (S_AXI_WDATA[7:4] > LAST_CH)) bresp_d = RESP_SLVERR;
`endif
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    en_d      = en_q;
    sel_d     = sel_q;
    auto_d    = auto_q;
    scratch_d = scratch_q;
    if (wr_ctrl && S_AXI_WSTRB[0]) begin
      en_d  = S_AXI_WDATA[0];
      sel_d = S_AXI_WDATA[7:4];
    end
    if (wr_ctrl && S_AXI_WSTRB[1]) auto_d = S_AXI_WDATA[8];
    for (int b = 0; b < DW / 8; b++) begin
      if (wr_scratch && S_AXI_WSTRB[b]) scratch_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      mvalid[k] = full_q & (buf_ch_q == 4'(k));
    end
  end

  assign hs      = mvalid & m_tready;
  assign drain   = |hs;
  assign s_ready = (state_q == ST_RUN) & (~full_q | drain);
  assign accept  = s_tvalid & s_ready;
  assign tgt_ch  = auto_q ? rr_ptr_q : clamp_ch(sel_q);
`ifdef EMUL_DEMUX_SEL_CHECK_EN
  assign drop    = ~auto_q & (sel_q > LAST_CH);
`else
  assign drop    = 1'b0;
`endif
  assign load    = accept & ~drop;

  always_comb begin
    full_d     = full_q;
    buf_ch_d   = buf_ch_q;
    buf_data_d = buf_data_q;
    rr_ptr_d   = rr_ptr_q;
    drop_d     = drop_q;
    if (load) begin
      full_d     = 1'b1;
      buf_ch_d   = tgt_ch;
      buf_data_d = s_tdata;
    end else if (drain) begin
      full_d = 1'b0;
    end
    // pointer restarts from the newly written SEL on an AUTO rising edge
    if (!auto_q && auto_d) rr_ptr_d = clamp_ch(sel_d);
    else if (accept && auto_q) rr_ptr_d = next_ch(rr_ptr_q);
`ifdef EMUL_DEMUX_SEL_CHECK_EN
    if (accept && drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
`else
    drop_d = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en_q) state_d = ST_RUN;
      ST_RUN:   if (!en_q) state_d = full_d ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!full_d) state_d = en_q ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // write-clear and a same-cycle handshake leave the counter at 1
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_clr[k]) cnt_d[k] = hs[k] ? CNT_W'(1) : '0;
      else if (hs[k] && (cnt_q[k] != CNT_MAX)) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      sel_q      <= '0;
      scratch_q  <= '0;
      full_q     <= 1'b0;
      buf_ch_q   <= '0;
      buf_data_q <= '0;
      rr_ptr_q   <= '0;
      drop_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      sel_q      <= sel_d;
      scratch_q  <= scratch_d;
      full_q     <= full_d;
      buf_ch_q   <= buf_ch_d;
      buf_data_q <= buf_data_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_q     <= drop_d;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign s_tready      = s_ready;
  assign m_tvalid      = mvalid;
  assign m_tdata       = buf_data_q;

endmodule

// File: tb/tb_emul_demux_sm_axil.sv
// Randomized bench for emul_demux_sm_axil: AXI register access and stream routing
// checked against a beat-queue reference model.
module tb_emul_demux_sm_axil;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int AW     = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     S_AXI_AWADDR = '0;
  logic [2:0]        S_AXI_AWPROT = '0;
  logic              S_AXI_AWVALID = 1'b0;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA = '0;
  logic [3:0]        S_AXI_WSTRB = '0;
  logic              S_AXI_WVALID = 1'b0;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY = 1'b0;
  logic [AW-1:0]     S_AXI_ARADDR = '0;
  logic [2:0]        S_AXI_ARPROT = '0;
  logic              S_AXI_ARVALID = 1'b0;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [NUM_CH-1:0] m_tvalid;
  logic [NUM_CH-1:0] m_tready = '1;

  always #5 clk = ~clk;

  emul_demux_sm_axil #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(32)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
  } beat_t;

  int     n_chk = 0;
  int     n_pass = 0;
  beat_t  exp_q[$];
  int     m_cnt[NUM_CH];
  bit     m_en = 0;
  bit     m_auto = 0;
  int     m_sel = 0;
  int     m_ptr = 0;
  int     m_drop = 0;
  logic [31:0] m_scratch = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int clamp(input int s);
    return (s > NUM_CH - 1) ? NUM_CH - 1 : s;
  endfunction

  function automatic logic [31:0] model_ctrl();
    return {23'b0, m_auto, 4'(m_sel), 3'b000, m_en};
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(negedge clk);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
    chk("awready", 32'(S_AXI_AWREADY), 1);
    chk("wready", 32'(S_AXI_WREADY), 1);
    @(negedge clk);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
    chk("bvalid", 32'(S_AXI_BVALID), 1);
    resp = S_AXI_BRESP;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    chk("arready", 32'(S_AXI_ARREADY), 1);
    @(negedge clk);
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
    chk("rvalid", 32'(S_AXI_RVALID), 1);
    chk("rresp", 32'(S_AXI_RRESP), 0);
    d = S_AXI_RDATA;
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  // applies a register write to the model first, then performs it on the bus
  task automatic reg_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] resp;
    logic [1:0] exp_resp;
    int idx;
    bit new_auto;
    int new_sel;
    exp_resp = 2'b00;
    idx = int'(a);
    if (idx == 0) begin
      new_sel  = s[0] ? int'(d[7:4]) : m_sel;
      new_auto = s[1] ? d[8] : m_auto;
      if (!m_auto && new_auto) m_ptr = clamp(new_sel);
`ifdef EMUL_DEMUX_SEL_CHECK_EN
      if (s[0] && int'(d[7:4]) >= NUM_CH) exp_resp = 2'b10;
`endif
      if (s[0]) m_en = d[0];
      m_sel  = new_sel;
      m_auto = new_auto;
    end else if (idx == 8) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    end else if (idx >= 12 && idx < 12 + 4 * NUM_CH && idx % 4 == 0) begin
      m_cnt[(idx - 12) / 4] = 0;
    end
    axi_write(a, d, s, resp);
    chk("bresp", 32'(resp), 32'(exp_resp));
  endtask

  task automatic expect_reg(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic model_accept(input logic [DATA_W-1:0] d);
    beat_t b;
    bit dropped;
    dropped = 0;
`ifdef EMUL_DEMUX_SEL_CHECK_EN
    if (!m_auto && m_sel >= NUM_CH) begin
      dropped = 1;
      if (m_drop < 65535) m_drop++;
    end
`endif
    if (!dropped) begin
      b.ch = m_auto ? m_ptr : clamp(m_sel);
      b.data = d;
      if (m_auto) m_ptr = (m_ptr + 1) % NUM_CH;
      exp_q.push_back(b);
    end
  endtask

  // call between negedge+1 and the next posedge: records handshakes occurring at that posedge
  task automatic observe();
    beat_t b;
    chk("onehot", 32'($countones(m_tvalid) <= 1), 1);
    for (int k = 0; k < NUM_CH; k++) begin
      if (m_tvalid[k] && m_tready[k]) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(m_tvalid), 0);
        end else begin
          b = exp_q.pop_front();
          chk("out_ch", k, b.ch);
          chk("out_data", 32'(m_tdata), 32'(b.data));
          m_cnt[k]++;
        end
      end
    end
  endtask

  task automatic run_stream(input int nbeats, input bit rand_rdy, output int cycles);
    int sent;
    bit acc;
    sent = 0;
    cycles = 0;
    @(posedge clk); #1;
    s_tdata = DATA_W'($urandom);
    s_tvalid = 1'b1;
    while (sent < nbeats && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      m_tready = rand_rdy ? NUM_CH'($urandom) : '1;
      #1;
      observe();
      acc = s_tvalid & s_tready;
      if (acc) model_accept(s_tdata);
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < nbeats) s_tdata = DATA_W'($urandom);
        else s_tvalid = 1'b0;
      end
    end
    s_tvalid = 1'b0;
    chk("beats_sent", sent, nbeats);
  endtask

  task automatic drain_out();
    m_tready = '1;
    repeat (4) begin
      @(negedge clk); #1;
      observe();
    end
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic load_one();
    @(posedge clk); #1;
    s_tdata = DATA_W'($urandom);
    s_tvalid = 1'b1;
    @(negedge clk); #1;
    chk("load_tready", 32'(s_tready), 1);
    if (s_tready) model_accept(s_tdata);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic check_status_cnts();
    expect_reg("status", 6'h04, {16'(m_drop), 8'h00, 4'h0, 1'b0, (m_en ? 2'd1 : 2'd0), 1'b0});
    for (int k = 0; k < NUM_CH; k++) expect_reg($sformatf("cnt%0d", k), AW'(12 + 4 * k), 32'(m_cnt[k]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [31:0] d;
    for (int k = 0; k < NUM_CH; k++) m_cnt[k] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_axi_ctl", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                            S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}), 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_stream", 32'({s_tready, m_tvalid}), 0);
    chk("rst_mdata", 32'(m_tdata), 0);
    rst_n = 1'b1;

    for (int a = 0; a <= 12 + 4 * (NUM_CH - 1); a += 4) expect_reg("rst_reg", AW'(a), 0);

    reg_write(6'h08, 32'hA5A5_5A5A, 4'h3);
    expect_reg("scratch_strb", 6'h08, m_scratch);
    expect_reg("unmapped", 6'h3C, 0);

    reg_write(6'h00, 32'h21, 4'hF);
    expect_reg("ctrl", 6'h00, model_ctrl());
    run_stream(5, 0, cyc);
    chk("throughput", cyc, 5);
    drain_out();
    check_status_cnts();

    for (int k = 0; k < NUM_CH; k++) reg_write(AW'(12 + 4 * k), $urandom, 4'hF);
    reg_write(6'h00, 32'h101, 4'hF);
    run_stream(6, 0, cyc);
    drain_out();
    check_status_cnts();

    reg_write(6'h00, 32'h0, 4'hF);
    reg_write(6'h00, 32'h11, 4'hF);
    m_tready = '0;
    load_one();
    reg_write(6'h00, 32'h0, 4'hF);
    expect_reg("status_drain", 6'h04, {16'(m_drop), 8'h00, 4'd1, 1'b0, 2'd2, 1'b1});
    @(negedge clk);
    s_tvalid = 1'b1;
    #1;
    chk("drain_tready", 32'(s_tready), 0);
    chk("drain_mvalid", 32'(m_tvalid), 32'(1) << exp_q[0].ch);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    drain_out();
    check_status_cnts();

    reg_write(6'h0C, 32'h0, 4'hF);
    reg_write(6'h00, 32'h01, 4'hF);
    run_stream(7, 0, cyc);
    drain_out();
    expect_reg("cnt0_seven", 6'h0C, 32'(m_cnt[0]));
    m_tready = '0;
    load_one();
    fork
      reg_write(6'h0C, 32'h0, 4'hF);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (S_AXI_AWREADY) break;
        end
        m_tready = '1;
        #1;
        observe();
        @(posedge clk); #1;
        m_tready = '0;
      end
    join
    expect_reg("cnt0_clr_inc", 6'h0C, 32'(m_cnt[0]));
    drain_out();

    reg_write(6'h00, 32'h71, 4'hF);
    run_stream(3, 0, cyc);
    drain_out();
    check_status_cnts();

    repeat (8) begin
      d = ($urandom & ~32'h1F1) | {23'b0, 1'($urandom), 4'($urandom), 3'b000, 1'b1};
      reg_write(6'h00, d, 4'hF);
      expect_reg("ctrl_rand", 6'h00, model_ctrl());
      run_stream($urandom_range(1, 12), 1, cyc);
      drain_out();
      check_status_cnts();
    end

    reg_write(6'h00, 32'h01, 4'hF);
    m_tready = '0;
    load_one();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mvalid", 32'(m_tvalid), 0);
    chk("async_rst_mdata", 32'(m_tdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int k = 0; k < NUM_CH; k++) m_cnt[k] = 0;
    m_en = 0; m_auto = 0; m_sel = 0; m_ptr = 0; m_drop = 0; m_scratch = '0;
    m_tready = '1;
    drain_out();
    expect_reg("rst_ctrl", 6'h00, model_ctrl());
    expect_reg("rst_scratch", 6'h08, m_scratch);
    check_status_cnts();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
